// File: rtl/bp_partial_del_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// bp_partial_del_accumulator_pkg
//   Shared sizing helpers for the partial-delta accumulator and its banks.
//   The depth, address width and counter width are derived here, so the top
//   and the bank compute them the same way.
// -----------------------------------------------------------------------------
package bp_partial_del_accumulator_pkg;

    // Entries per bank: the p neurons of the preceding layer are spread over z banks.
    function automatic int calc_depth(input int p, input int z);
        return p / z;
    endfunction

    // Entry index width. A single-entry bank still carries a 1-bit index.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The hit counter must hold the values 0..fo.
    function automatic int calc_cw(input int fo);
        return $clog2(fo + 1);
    endfunction

endpackage

// File: rtl/bp_partial_del_accumulator_del_bank.sv
// -----------------------------------------------------------------------------
// del_bank
//   One bank of the partial-delta accumulator. It holds DEPTH running sums and
//   DEPTH hit counters, and does one read (stage R) and one write (stage W)
//   per cycle.
//   Ports:
//     clk, reset_n    clock, asynchronous active-low reset
//     i_valid         a read address is presented this cycle
//     i_rd_addr       entry to read (stage R)
//     i_del_in        updated sum returned by the BP set for the entry in stage W
//     o_rd_data       registered stored sum that goes to the BP set
//     o_delp_valid    1-cycle pulse: o_delp_out/o_delp_addr hold a finished delta
//     o_delp_addr     entry index of the finished delta
//     o_delp_out      finished delta value
// -----------------------------------------------------------------------------
module del_bank
    import bp_partial_del_accumulator_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int FO    = 2,
    parameter int AW    = calc_aw(DEPTH),
    parameter int CW    = calc_cw(FO)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [AW-1:0]    i_rd_addr,
    input  logic [WIDTH-1:0] i_del_in,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_delp_valid,
    output logic [AW-1:0]    o_delp_addr,
    output logic [WIDTH-1:0] o_delp_out
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_cnt [DEPTH];
    logic             r_v_q;
    logic [AW-1:0]    r_addr_q;

    logic [CW-1:0]    w_cnt_next;
    logic             w_done;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_fwd;

    always_comb begin
        w_cnt_next = r_cnt[r_addr_q] + CW'(1);
        w_done     = r_v_q && (w_cnt_next == CW'(FO));
        // A completed entry restarts from zero, ready for the next sample.
        w_wr_data  = w_done ? '0 : i_del_in;
        // Stage R reads the entry that stage W is writing in the same cycle.
        w_fwd      = i_valid && r_v_q && (i_rd_addr == r_addr_q);
    end

    // NOTE: the array stays in flops rather than RAM so that every entry and
    // counter clears on the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_v_q        <= 1'b0;
            r_addr_q     <= '0;
            o_rd_data    <= '0;
            o_delp_valid <= 1'b0;
            o_delp_addr  <= '0;
            o_delp_out   <= '0;
        end else begin
            r_v_q        <= i_valid;
            o_delp_valid <= w_done;

            // NOTE: the assignments are non-blocking, so the read below sees the
            // array as it was before this edge. The forwarding path supplies the
            // value being written to the same entry in this cycle.
            if (i_valid) begin
                r_addr_q  <= i_rd_addr;
                o_rd_data <= w_fwd ? w_wr_data : r_mem[i_rd_addr];
            end

            // The counter is written back here, so a back-to-back access to the
            // same entry already sees the new count in the next cycle.
            if (r_v_q) begin
                r_mem[r_addr_q] <= w_wr_data;
                r_cnt[r_addr_q] <= w_done ? '0 : w_cnt_next;
            end

            if (w_done) begin
                o_delp_out  <= i_del_in;
                o_delp_addr <= r_addr_q;
            end
        end
    end

endmodule

// File: rtl/bp_partial_del_accumulator.sv
// -----------------------------------------------------------------------------
// bp_partial_del_accumulator
//   Storage and accumulation stage around the BP processor set. It keeps the p
//   running partial delta sums of the preceding layer in z independent banks.
//   Each cycle it sends the addressed sums to the BP set and writes the updated
//   sums back on the next cycle. After fo contributions it releases the
//   finished delta of a neuron as a one-cycle pulse.
//   Ports (bank i occupies slice i of every packed bus):
//     clk                      rising-edge clock
//     reset_n                  asynchronous active-low reset
//     in_valid                 rd_addr_package is valid this cycle
//     rd_addr_package          [AW*z]    per-bank entry index
//     partial_del_out_package  [width*z] stored sums, 1-cycle read latency
//     del_out_package          [width*z] updated sums from the BP set (combinational)
//     delp_valid               [z]       per-bank finished-delta pulse
//     delp_addr_package        [AW*z]    entry index of each finished delta
//     delp_out_package         [width*z] finished delta values
// -----------------------------------------------------------------------------
module bp_partial_del_accumulator
    import bp_partial_del_accumulator_pkg::*;
#(
    parameter  int p     = 16,
    parameter  int z     = 8,
    parameter  int fo    = 2,
    parameter  int width = 16,
    localparam int DEPTH = calc_depth(p, z),
    localparam int AW    = calc_aw(DEPTH),
    localparam int CW    = calc_cw(fo)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [AW*z-1:0]      rd_addr_package,
    output logic [width*z-1:0]   partial_del_out_package,
    input  logic [width*z-1:0]   del_out_package,
    output logic [z-1:0]         delp_valid,
    output logic [AW*z-1:0]      delp_addr_package,
    output logic [width*z-1:0]   delp_out_package
);

    for (genvar g = 0; g < z; g++) begin : g_bank
        del_bank #(
            .DEPTH (DEPTH),
            .WIDTH (width),
            .FO    (fo),
            .AW    (AW),
            .CW    (CW)
        ) u_bank (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_valid      (in_valid),
            .i_rd_addr    (rd_addr_package[g*AW +: AW]),
            .i_del_in     (del_out_package[g*width +: width]),
            .o_rd_data    (partial_del_out_package[g*width +: width]),
            .o_delp_valid (delp_valid[g]),
            .o_delp_addr  (delp_addr_package[g*AW +: AW]),
            .o_delp_out   (delp_out_package[g*width +: width])
        );
    end

endmodule

// File: tb/tb_bp_partial_del_accumulator.sv
// -----------------------------------------------------------------------------
// tb_bp_partial_del_accumulator
//   Directed bench. The BP set is modelled as del_out = partial_del_out + k,
//   where k is chosen per bank and per entry, for the entry in stage W.
// -----------------------------------------------------------------------------
module tb_bp_partial_del_accumulator;

    localparam int Z  = 8;
    localparam int W  = 16;
    localparam int AW = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [AW*Z-1:0]  rd_addr_package;
    logic [W*Z-1:0]   partial_del_out_package;
    logic [W*Z-1:0]   del_out_package;
    logic [Z-1:0]     delp_valid;
    logic [AW*Z-1:0]  delp_addr_package;
    logic [W*Z-1:0]   delp_out_package;

    bp_partial_del_accumulator #(
        .p     (16),
        .z     (Z),
        .fo    (2),
        .width (W)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .in_valid                (in_valid),
        .rd_addr_package         (rd_addr_package),
        .partial_del_out_package (partial_del_out_package),
        .del_out_package         (del_out_package),
        .delp_valid              (delp_valid),
        .delp_addr_package       (delp_addr_package),
        .delp_out_package        (delp_out_package)
    );

    always #5 clk = ~clk;

    // BP set model: the entry in stage W is the one addressed on the previous valid cycle.
    logic [W-1:0]  k_tab [Z][2];
    logic [Z-1:0]  tb_addr_q = '0;

    always @(posedge clk) if (in_valid) tb_addr_q <= rd_addr_package;

    always_comb begin
        del_out_package = '0;
        for (int b = 0; b < Z; b++)
            del_out_package[b*W +: W] = partial_del_out_package[b*W +: W] + k_tab[b][tb_addr_q[b]];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pd(input int b);
        return partial_del_out_package[b*W +: W];
    endfunction

    function automatic logic [W-1:0] dout(input int b);
        return delp_out_package[b*W +: W];
    endfunction

    task automatic cycle(input logic v, input logic [Z-1:0] addr);
        in_valid        = v;
        rd_addr_package = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_k();
        for (int b = 0; b < Z; b++) begin
            k_tab[b][0] = '0;
            k_tab[b][1] = '0;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
    endtask

    initial begin
        clear_k();
        reset_n         = 1'b0;
        in_valid        = 1'b0;
        rd_addr_package = '0;
        #1;
        check("por_partial", partial_del_out_package, '0);
        check("por_delp_valid", delp_valid, '0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_delp_out", delp_out_package, '0);
        check("rst_delp_addr", delp_addr_package, '0);

        // Two hits on entry 1 with three idle cycles between them.
        k_tab[0][1] = 16'd5;
        for (int b = 1; b < Z; b++) k_tab[b][1] = W'(b);
        cycle(1'b1, 8'hFF);
        check("b_rd0_bank0", pd(0), 16'd0);
        cycle(1'b0, 8'h00);
        check("b_idle1_valid", delp_valid, 8'h00);
        cycle(1'b0, 8'h00);
        check("b_idle2_valid", delp_valid, 8'h00);
        cycle(1'b0, 8'h00);
        check("b_idle3_valid", delp_valid, 8'h00);
        check("b_idle_hold", pd(0), 16'd0);
        cycle(1'b1, 8'hFF);
        check("b_rd1_bank0", pd(0), 16'd5);
        check("b_rd1_bank3", pd(3), 16'd3);
        cycle(1'b0, 8'h00);
        check("b_pulse_valid", delp_valid, 8'hFF);
        check("b_pulse_out0", dout(0), 16'd10);
        check("b_pulse_out3", dout(3), 16'd6);
        check("b_pulse_addr", delp_addr_package, 8'hFF);
        cycle(1'b0, 8'h00);
        check("b_pulse_end", delp_valid, 8'h00);
        check("b_out_hold", dout(0), 16'd10);
        cycle(1'b1, 8'hFF);
        check("b_rd_cleared", pd(0), 16'd0);

        // Reset asserted while a stage-W write is pending.
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hFF);
        check("r_pre_partial", pd(0), 16'd5);
        reset_n = 1'b0;
        #1;
        check("r_async_partial", partial_del_out_package, '0);
        check("r_async_out", delp_out_package, '0);
        check("r_async_addr", delp_addr_package, '0);
        check("r_async_valid", delp_valid, '0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 8'hFF);
        check("r_rd_after", pd(0), 16'd0);
        cycle(1'b0, 8'h00);
        check("r_cnt_cleared", delp_valid, 8'h00);

        // Three back-to-back accesses to entry 0.
        do_reset();
        clear_k();
        for (int b = 0; b < Z; b++) k_tab[b][0] = 16'd3;
        cycle(1'b1, 8'h00);
        check("c_rd0", pd(3), 16'd0);
        cycle(1'b1, 8'h00);
        check("c_fwd_sum", pd(3), 16'd3);
        check("c_no_pulse", delp_valid, 8'h00);
        cycle(1'b1, 8'h00);
        check("c_fwd_zero", pd(3), 16'd0);
        check("c_pulse_valid", delp_valid, 8'hFF);
        check("c_pulse_out3", dout(3), 16'd6);
        cycle(1'b0, 8'h00);
        check("c_restart", delp_valid, 8'h00);

        // Bank 0 alternates between entries 0 and 1; other banks stay on entry 0.
        do_reset();
        clear_k();
        k_tab[0][0] = 16'd1;
        k_tab[0][1] = 16'hFFFE;
        cycle(1'b1, 8'h00);
        check("d_rd_a0", pd(0), 16'd0);
        cycle(1'b1, 8'h01);
        check("d_rd_a1", pd(0), 16'd0);
        check("d_valid1", delp_valid, 8'h00);
        cycle(1'b1, 8'h00);
        check("d_rd_a0_again", pd(0), 16'd1);
        check("d_valid2", delp_valid, 8'hFE);
        cycle(1'b1, 8'h01);
        check("d_rd_a1_again", pd(0), 16'hFFFE);
        check("d_valid3", delp_valid, 8'h01);
        check("d_out_a0", dout(0), 16'd2);
        check("d_addr_a0", delp_addr_package, 8'h00);
        cycle(1'b0, 8'h00);
        check("d_valid4", delp_valid, 8'hFF);
        check("d_out_a1", dout(0), 16'hFFFC);
        check("d_addr_a1", delp_addr_package, 8'h01);
        cycle(1'b0, 8'h00);
        check("d_valid5", delp_valid, 8'h00);

        // 0x8000 + 0x8000 wraps to 0 without saturation.
        k_tab[0][1] = 16'h8000;
        cycle(1'b1, 8'h01);
        check("e_rd0", pd(0), 16'd0);
        cycle(1'b0, 8'h00);
        check("e_no_pulse", delp_valid, 8'h00);
        cycle(1'b1, 8'h01);
        check("e_rd1", pd(0), 16'h8000);
        cycle(1'b0, 8'h00);
        check("e_valid", delp_valid, 8'hFF);
        check("e_wrap_out", dout(0), 16'h0000);
        check("e_addr", delp_addr_package[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
